uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Frame serializer for the response path of the UART command system. It takes one parallel byte from the system controller, which drives TX data and its valid strobe. It emits the byte on a single serial line in the frame format the RX side accepts: a start bit, 8 data bits LSB first, an optional even/odd parity bit and one stop bit. Bit timing is generated internally from a per-frame prescale value. The block is therefore driven by the UART-domain clock directly, with no external bit-rate clock.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE_WIDTH, 6, width of the PRESCALE input (REG2[7:2] in the register map)

Ports:
- CLK  in  1  UART-domain clock. The design has only this one clock.
- RST  in  1  synchronous, active-high reset
- P_DATA  in  DATA_WIDTH  byte to send
- DATA_VALID  in  1  request strobe. It is level-sampled.
- PAR_EN  in  1  1 = insert parity bit (REG2[0])
- PAR_TYP  in  1  0 = even parity, 1 = odd parity (REG2[1])
- PRESCALE  in  PRESCALE_WIDTH  CLK cycles per serial bit. A value of 0 means 64.
- TX_OUT  out  1  serial line. It idles high.
- BUSY  out  1  high while a frame is in progress
- TX_DONE  out  1  one-cycle pulse in the last cycle of the stop bit

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- **Accept:** the block accepts a request only in IDLE, on any edge where DATA_VALID=1. On that edge it:
  - latches P_DATA, PAR_EN, PAR_TYP and PRESCALE into frame registers;
  - computes the parity bit from the latched data (even: ^data; odd: ~^data);
  - moves to START.
- Changes to the inputs after the accept edge do not affect the frame in flight.
- DATA_VALID is ignored outside IDLE. The upstream block must hold the request until it sees BUSY=1, then drop it.
- Each state lasts exactly P CLK cycles, where P is the latched prescale (0 maps to 64). A bit-cycle counter runs from 0 to P-1 and resets on every state change.
- **START:** TX_OUT=0.
- **DATA:** TX_OUT = data[bit_idx]. bit_idx starts at 0 and increments each time the counter reaches P-1. The block leaves DATA after bit_idx=7.
- **PARITY:** TX_OUT = latched parity bit. If PAR_EN=0 (latched), this state is skipped and DATA goes directly to STOP.
- **STOP:** TX_OUT=1. In the last cycle, TX_DONE=1; on the next edge the block returns to IDLE and BUSY falls.
- **Frame length:** 11·P cycles with parity, 10·P cycles without.
- **Reset:** synchronous, and it has priority over everything, including mid-frame. At the next edge after RST=1: state=IDLE, TX_OUT=1, BUSY=0, TX_DONE=0, counters=0, frame registers=0. An aborted frame never produces TX_DONE.
- **Simultaneous events:** DATA_VALID in the TX_DONE cycle is ignored, because the block is still in STOP. This guarantees at least one idle-high cycle between frames.

## Timing
- **Reset values:** TX_OUT=1, BUSY=0, TX_DONE=0.
- **Outputs are registered:** TX_OUT, BUSY and TX_DONE are registered with no combinational path from any input.
- **Accept edge k:**
  - from edge k: TX_OUT=0 and BUSY=1;
  - first data bit from edge k+P;
  - TX_DONE is high during cycle k+(N·P)-1, where N=10 or 11;
  - BUSY=0 and TX_OUT=1 from edge k+N·P.
- **Minimum request-to-request spacing:** N·P+1 cycles.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - PAR_EVEN=0 and PAR_ODD=1;
  - DEFAULT_PRESCALE=32;
  - STOP_BITS=1.
- One sub-module, uart_bit_timer: the bit-cycle counter with inputs load/P and output last_cycle. It is reused by the RX oversampler.
- The FSM, bit index, shift register and parity are inline.

## Test plan
- **Even-parity frame:** after reset, PRESCALE=32, PAR_EN=1, PAR_TYP=0, send 0x81. Expect TX_OUT to read 0,1,0,0,0,0,0,0,1,0(parity),1, each bit exactly 32 cycles. Expect BUSY high for 352 cycles and one TX_DONE pulse at cycle 351.
- **Odd parity, no parity:**
  - Send 0x37 with PAR_TYP=1: expect parity bit 0. 0x37 has five ones; even parity would be 1.
  - Send 0x0F with PAR_EN=0: expect a 10-bit frame, stop bit immediately after data bit 7, BUSY high for 320 cycles.
- **Prescale edge cases:**
  - PRESCALE=1 sending 0x55: expect 11-cycle frame, bits alternate 1,0 from LSB.
  - PRESCALE=0: expect 64 cycles/bit.
- **Input stability:** change P_DATA, PAR_EN and PRESCALE, and pulse DATA_VALID, mid-frame while sending 0xAA. Expect the frame to be unchanged and no second frame to start. DATA_VALID held through TX_DONE starts the next frame exactly 1 idle cycle after BUSY falls.
- **Reset mid-frame:** assert RST during DATA bit 3 of 0xBB. Expect TX_OUT=1 and BUSY=0 at the next edge, no TX_DONE. Then a new 0x04 frame is transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEFAULT_PRESCALE = 32;
  localparam int STOP_BITS        = 1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - request and serial-line signals of the TX serializer
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);

  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic                      TX_OUT;
  logic                      BUSY;
  logic                      TX_DONE;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PRESCALE,
    input  TX_OUT, BUSY, TX_DONE
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PRESCALE,
    output TX_OUT, BUSY, TX_DONE
  );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-cycle counter running 0..p-1, shared with the RX oversampler
module uart_bit_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] p,
  output logic             last_cycle,
  output logic [WIDTH-1:0] count
);

  assign last_cycle = (count == p - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (last_cycle) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - start/data/parity/stop frame serializer with per-frame prescale
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_serializer_if.slave  bus
);

  localparam int PW = PRESCALE_WIDTH + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic [PW-1:0]         p_lat;
  logic [IW-1:0]         bit_idx;
  logic                  tx_out_r;
  logic                  busy_r;
  logic                  tx_done_r;

  logic                  last_cycle;
  logic [PW-1:0]         count;
  logic                  timer_load;
  logic [PW-1:0]         p_req;
  logic                  last_bit;
  logic                  to_stop;

  // A zero prescale encodes the full 2**PRESCALE_WIDTH cycles per bit.
  assign p_req      = (bus.PRESCALE == '0) ? PW'(2**PRESCALE_WIDTH) : PW'(bus.PRESCALE);
  assign timer_load = (state == S_IDLE);
  assign last_bit   = (bit_idx == IW'(DATA_WIDTH - 1));
  assign to_stop    = last_cycle &&
                      (((state == S_DATA) && last_bit && !par_en_r) || (state == S_PARITY));

  uart_bit_timer #(
    .WIDTH(PW)
  ) u_bit_timer (
    .clk       (CLK),
    .rst       (RST),
    .load      (timer_load),
    .p         (p_lat),
    .last_cycle(last_cycle),
    .count     (count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      shreg     <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      p_lat     <= '0;
      bit_idx   <= '0;
      tx_out_r  <= 1'b1;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      // TX_DONE is registered, so it is raised one edge ahead of the final STOP cycle.
      tx_done_r <= (to_stop && (p_lat == PW'(1))) ||
                   ((state == S_STOP) && !last_cycle && (count == p_lat - PW'(2)));

      case (state)
        S_IDLE: begin
          if (bus.DATA_VALID) begin
            shreg     <= bus.P_DATA;
            par_en_r  <= bus.PAR_EN;
            par_bit_r <= (bus.PAR_TYP == PAR_ODD) ? ~^bus.P_DATA : ^bus.P_DATA;
            p_lat     <= p_req;
            bit_idx   <= '0;
            state     <= S_START;
            tx_out_r  <= 1'b0;
            busy_r    <= 1'b1;
          end
        end
        S_START: begin
          if (last_cycle) begin
            state    <= S_DATA;
            tx_out_r <= shreg[0];
          end
        end
        S_DATA: begin
          if (last_cycle) begin
            if (!last_bit) begin
              bit_idx  <= bit_idx + IW'(1);
              shreg    <= shreg >> 1;
              tx_out_r <= shreg[1];
            end else if (par_en_r) begin
              state    <= S_PARITY;
              tx_out_r <= par_bit_r;
            end else begin
              state    <= S_STOP;
              tx_out_r <= 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (last_cycle) begin
            state    <= S_STOP;
            tx_out_r <= 1'b1;
          end
        end
        S_STOP: begin
          if (last_cycle) begin
            state    <= S_IDLE;
            busy_r   <= 1'b0;
            tx_out_r <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy_r   <= 1'b0;
          tx_out_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.TX_OUT  = tx_out_r;
  assign bus.BUSY    = busy_r;
  assign bus.TX_DONE = tx_done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer frames
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_serializer_if bus ();

  uart_tx_serializer dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    int          id;
    logic [10:0] bits;
    int          nbits;
    int          p;
    int          abort_len;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic exp_t make_exp(input int id, input logic [7:0] d, input logic pe,
                                    input logic par, input logic [5:0] ps,
                                    input int abort_len, input int gap);
    exp_t e;
    e.id        = id;
    e.bits      = '0;
    e.bits[8:1] = d;
    if (pe) begin
      e.bits[9]  = par;
      e.bits[10] = 1'b1;
      e.nbits    = 11;
    end else begin
      e.bits[9]  = 1'b1;
      e.nbits    = 10;
    end
    e.p         = (ps == 6'd0) ? 64 : int'(ps);
    e.abort_len = abort_len;
    e.gap       = gap;
    return e;
  endfunction

  task automatic wait_busy(input logic level, input int bound, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.BUSY !== level && n < bound);
    check({name, "_timeout"}, int'(bus.BUSY === level), 1);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    @(negedge clk);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.PRESCALE   = ps;
    bus.DATA_VALID = 1'b1;
    wait_busy(1'b1, 100, "accept");
    bus.DATA_VALID = 1'b0;
  endtask

  // Monitor: captures each BUSY window and scores it against the oldest expected frame.
  initial begin : monitor
    exp_t e;
    logic cap[$];
    logic prev_busy;
    int   len, explen, errs, first, done_cnt, done_pos, idle, gap_seen;
    prev_busy = 1'b0;
    idle      = 1000;
    len       = 0;
    done_cnt  = 0;
    done_pos  = -1;
    gap_seen  = 0;
    forever begin
      @(negedge clk);
      if (bus.BUSY === 1'b1) begin
        if (prev_busy !== 1'b1) begin
          cap.delete();
          len      = 0;
          done_cnt = 0;
          done_pos = -1;
          gap_seen = idle;
        end
        if (bus.TX_DONE === 1'b1) begin
          done_cnt++;
          done_pos = len;
        end
        cap.push_back(bus.TX_OUT);
        len++;
      end else begin
        if (prev_busy === 1'b1) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_frame_len_%0d", len), 1, 0);
          end else begin
            e      = exp_q.pop_front();
            explen = (e.abort_len > 0) ? e.abort_len : e.nbits * e.p;
            check($sformatf("f%0d_busy_len", e.id), len, explen);
            errs  = 0;
            first = -1;
            for (int i = 0; i < len && i < explen; i++) begin
              if (cap[i] !== e.bits[i / e.p]) begin
                errs++;
                if (first < 0) first = i;
              end
            end
            check($sformatf("f%0d_wave_errors_first_at_%0d", e.id, first), errs, 0);
            if (e.abort_len > 0) begin
              check($sformatf("f%0d_done_count", e.id), done_cnt, 0);
            end else begin
              check($sformatf("f%0d_done_count", e.id), done_cnt, 1);
              check($sformatf("f%0d_done_pos", e.id), done_pos, explen - 1);
            end
            check($sformatf("f%0d_idle_high", e.id), int'(bus.TX_OUT === 1'b1), 1);
            if (e.gap >= 0) check($sformatf("f%0d_gap", e.id), gap_seen, e.gap);
          end
          idle = 1;
        end else begin
          idle++;
        end
      end
      prev_busy = bus.BUSY;
    end
  end

  logic [7:0] v_data[5] = '{8'h81, 8'h37, 8'h0F, 8'h55, 8'hC3};
  logic       v_pe  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       v_pt  [5] = '{PAR_EVEN, PAR_ODD, PAR_EVEN, PAR_EVEN, PAR_ODD};
  logic [5:0] v_ps  [5] = '{6'(DEFAULT_PRESCALE), 6'd32, 6'd32, 6'd1, 6'd0};
  logic       v_par [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin : stimulus
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.PRESCALE   = '0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_out", int'(bus.TX_OUT === 1'b1), 1);
    check("reset_busy", int'(bus.BUSY === 1'b0), 1);
    check("reset_tx_done", int'(bus.TX_DONE === 1'b0), 1);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(make_exp(i + 1, v_data[i], v_pe[i], v_par[i], v_ps[i], 0, -1));
      send(v_data[i], v_pe[i], v_pt[i], v_ps[i]);
      wait_busy(1'b0, 2000, $sformatf("f%0d_end", i + 1));
    end

    exp_q.push_back(make_exp(6, 8'hAA, 1'b1, 1'b0, 6'd8, 0, -1));
    send(8'hAA, 1'b1, PAR_EVEN, 6'd8);
    repeat (20) @(negedge clk);
    bus.P_DATA     = 8'h3C;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = PAR_ODD;
    bus.PRESCALE   = 6'd2;
    bus.DATA_VALID = 1'b1;
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
    repeat (30) @(negedge clk);
    exp_q.push_back(make_exp(7, 8'h3C, 1'b0, 1'b0, 6'd2, 0, 1));
    bus.DATA_VALID = 1'b1;
    wait_busy(1'b0, 200, "hold_fall");
    wait_busy(1'b1, 10, "hold_rise");
    bus.DATA_VALID = 1'b0;
    wait_busy(1'b0, 200, "f7_end");

    exp_q.push_back(make_exp(8, 8'hBB, 1'b1, 1'b0, 6'd4, 18, -1));
    send(8'hBB, 1'b1, PAR_EVEN, 6'd4);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_out", int'(bus.TX_OUT === 1'b1), 1);
    check("abort_busy", int'(bus.BUSY === 1'b0), 1);
    check("abort_tx_done", int'(bus.TX_DONE === 1'b0), 1);
    rst = 1'b0;

    exp_q.push_back(make_exp(9, 8'h04, 1'b1, 1'b1, 6'd4, 0, -1));
    send(8'h04, 1'b1, PAR_EVEN, 6'd4);
    wait_busy(1'b0, 200, "f9_end");

    repeat (10) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
